// File: rtl/int_ctrl.sv
// Interrupt controller: latches up to 8 level/edge sources, masks them, drives a registered priority one-hot to the CPU.
// Optional INTC_SYNC_EN adds a 2-flop synchronizer on each source ahead of edge detect and level sampling.
module int_ctrl #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic                sys_clk,
  input  logic                sys_reset,
  input  logic [NUM_SRC-1:0]  irq_src_i,
  input  logic                wr_en_i,
  input  logic [31:0]         wr_addr_i,
  input  logic [31:0]         wr_data_i,
  input  logic [31:0]         rd_addr_i,
  output logic [31:0]         rd_data_o,
  output logic [7:0]          int_flag_o
);

  localparam int unsigned MASK_INT = (1 << NUM_SRC) - 1;
  localparam logic [7:0]  SRC_MASK = 8'(MASK_INT);

  localparam logic [3:0] ADDR_ENABLE  = 4'h0;
  localparam logic [3:0] ADDR_TRIG    = 4'h4;
  localparam logic [3:0] ADDR_PENDING = 4'h8;
  localparam logic [3:0] ADDR_ID      = 4'hC;

  logic [7:0] en_q, en_d;
  logic [7:0] trig_q, trig_d;
  logic [7:0] pend_q, pend_d;
  logic [7:0] src_d_q;
  logic [7:0] flag_q, flag_d;
  logic [7:0] src_s;
  logic [7:0] src_edge;
  logic [7:0] w1c;
  logic [7:0] active;
  logic       id_valid;
  logic [2:0] id_idx;

  logic unused_bits;
  assign unused_bits = ^{wr_addr_i[31:4], rd_addr_i[31:4], wr_data_i[31:8]};

`ifdef INTC_SYNC_EN
  logic [7:0] sync1_q, sync2_q;

  // Two-stage synchronizer for sources from other clock domains.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      sync1_q <= 8'(irq_src_i) & SRC_MASK;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = 8'(irq_src_i) & SRC_MASK;
`endif

  assign src_edge = src_s & ~src_d_q;
  assign active   = pend_q & en_q;

  // Lowest index among pending-and-enabled sources wins.
  always_comb begin
    id_valid = 1'b0;
    id_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) begin
        id_valid = 1'b1;
        id_idx   = 3'(i);
      end
    end
  end

  // Register writes, pending update and next interrupt flag.
  always_comb begin
    en_d   = en_q;
    trig_d = trig_q;
    w1c    = 8'h00;
    flag_d = 8'h00;
    if (wr_en_i && (wr_addr_i[3:0] == ADDR_ENABLE)) en_d = wr_data_i[7:0] & SRC_MASK;
    if (wr_en_i && (wr_addr_i[3:0] == ADDR_TRIG))   trig_d = wr_data_i[7:0] & SRC_MASK;
    if (wr_en_i && (wr_addr_i[3:0] == ADDR_PENDING)) w1c = wr_data_i[7:0];
    // Edge bits: set beats W1C on the same edge. Level bits: follow the sample.
    pend_d = ((trig_q & ((pend_q & ~w1c) | src_edge)) | (~trig_q & src_s)) & SRC_MASK;
    if (id_valid) flag_d = 8'b1 << id_idx;
  end

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      en_q    <= 8'h00;
      trig_q  <= 8'h00;
      pend_q  <= 8'h00;
      src_d_q <= 8'h00;
      flag_q  <= 8'h00;
    end else begin
      en_q    <= en_d;
      trig_q  <= trig_d;
      pend_q  <= pend_d;
      src_d_q <= src_s;
      flag_q  <= flag_d;
    end
  end

  // Combinational read port; a same-cycle write is not yet visible.
  always_comb begin
    rd_data_o = 32'h0;
    case (rd_addr_i[3:0])
      ADDR_ENABLE:  rd_data_o = {24'h0, en_q};
      ADDR_TRIG:    rd_data_o = {24'h0, trig_q};
      ADDR_PENDING: rd_data_o = {24'h0, pend_q};
      ADDR_ID:      rd_data_o = {id_valid, 28'h0, id_idx};
      default:      rd_data_o = 32'h0;
    endcase
  end

  assign int_flag_o = flag_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; expected values are hand-derived per step.
module tb_int_ctrl;

`ifdef INTC_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq_src;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  int_flag;

  int checks;
  int failures;

  int_ctrl #(.NUM_SRC(8)) dut (
    .sys_clk    (clk),
    .sys_reset  (rst_n),
    .irq_src_i  (irq_src),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .int_flag_o (int_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd_addr = a;
    #1;
    chk(tag, rd_data, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    irq_src  = 8'h00;
    wr_en    = 1'b0;
    wr_addr  = 32'h0;
    wr_data  = 32'h0;
    rd_addr  = 32'h0;

    // Reset state
    #12 rst_n = 1'b1;
    tick();
    chk_rd("rst_enable", 32'h0, 32'h0);
    chk_rd("rst_trig",   32'h4, 32'h0);
    chk_rd("rst_pend",   32'h8, 32'h0);
    chk_rd("rst_id",     32'hC, 32'h0);
    chk("rst_flag", {24'h0, int_flag}, 32'h0);

    // Edge pulse on source 0, then W1C
    wr(32'h0, 32'h01);
    wr(32'h4, 32'h01);
    chk_rd("trig_rb", 32'h4, 32'h01);
    chk_rd("misaligned_rd", 32'h5, 32'h0);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    ticks(SYNC);
    chk_rd("e0_pend", 32'h8, 32'h01);
    chk_rd("e0_id",   32'hC, 32'h8000_0000);
    chk("e0_flag_early", {24'h0, int_flag}, 32'h00);
    tick();
    chk("e0_flag", {24'h0, int_flag}, 32'h01);
    wr(32'h8, 32'h01);
    chk_rd("e0_w1c_pend", 32'h8, 32'h00);
    chk("e0_w1c_flag_hold", {24'h0, int_flag}, 32'h01);
    tick();
    chk("e0_w1c_flag", {24'h0, int_flag}, 32'h00);

    // Level sources 2 and 3, priority
    wr(32'h4, 32'h00);
    wr(32'h0, 32'hFF);
    irq_src = 8'h0C;
    ticks(1 + SYNC);
    chk_rd("lv_pend", 32'h8, 32'h0C);
    chk_rd("lv_id2",  32'hC, 32'h8000_0002);
    tick();
    chk("lv_flag2", {24'h0, int_flag}, 32'h04);
    irq_src = 8'h08;
    ticks(1 + SYNC);
    chk_rd("lv_id3", 32'hC, 32'h8000_0003);
    tick();
    chk("lv_flag3", {24'h0, int_flag}, 32'h08);
    wr(32'h8, 32'hFF);
    chk_rd("lv_w1c_ignored", 32'h8, 32'h08);
    tick();
    chk("lv_flag_kept", {24'h0, int_flag}, 32'h08);
    irq_src = 8'h00;
    ticks(1 + SYNC);
    chk_rd("lv_drop", 32'h8, 32'h00);
    tick();
    chk("lv_drop_flag", {24'h0, int_flag}, 32'h00);

    // Masked source 5 pending, then enable
    wr(32'h0, 32'h00);
    wr(32'h4, 32'h20);
    irq_src = 8'h20;
    tick();
    irq_src = 8'h00;
    ticks(SYNC);
    chk_rd("m5_pend", 32'h8, 32'h20);
    chk_rd("m5_id_masked", 32'hC, 32'h0);
    tick();
    chk("m5_flag_masked", {24'h0, int_flag}, 32'h00);
    wr(32'h0, 32'h20);
    chk("m5_flag_lag", {24'h0, int_flag}, 32'h00);
    tick();
    chk("m5_flag", {24'h0, int_flag}, 32'h20);
    wr(32'h8, 32'h20);
    wr(32'h0, 32'h00);

    // Set beats W1C on source 1; held-high source does not re-set
    wr(32'h4, 32'h02);
    irq_src = 8'h02;
    ticks(SYNC);
    wr(32'h8, 32'h02);
    chk_rd("s1_set_wins", 32'h8, 32'h02);
    wr(32'h8, 32'h02);
    chk_rd("s1_w1c", 32'h8, 32'h00);
    ticks(3);
    chk_rd("s1_held_no_reset", 32'h8, 32'h00);
    irq_src = 8'h00;
    ticks(1 + SYNC);
    irq_src = 8'h02;
    ticks(1 + SYNC);
    chk_rd("s1_rerise", 32'h8, 32'h02);

    // Edge to level: pending kept for one edge, then follows sample
    irq_src = 8'h00;
    ticks(1 + SYNC);
    wr(32'h4, 32'h00);
    chk_rd("e2l_kept", 32'h8, 32'h02);
    tick();
    chk_rd("e2l_follow", 32'h8, 32'h00);

    // Unmapped/misaligned writes ignored
    wr(32'h2, 32'hFF);
    wr(32'hC, 32'hFF);
    chk_rd("bad_wr_enable", 32'h0, 32'h00);
    chk_rd("bad_wr_trig",   32'h4, 32'h00);

    // Async reset mid-interrupt
    wr(32'h0, 32'h01);
    wr(32'h4, 32'h01);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    ticks(1 + SYNC);
    chk("ar_flag_before", {24'h0, int_flag}, 32'h01);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_flag_async", {24'h0, int_flag}, 32'h00);
    chk_rd("ar_pend", 32'h8, 32'h00);
    chk_rd("ar_enable", 32'h0, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(2);
    chk("ar_flag_after", {24'h0, int_flag}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller between the SoC peripherals' interrupt lines (timer, uart, gpio, spare) and the CPU's 8-bit `int_flag_i`. It latches up to 8 sources as level or rising-edge triggered and masks them per source. It presents a registered one-hot of the highest-priority active source to the CPU. It is a bus slave with the same five-signal register port as the other peripherals, so software can configure, inspect and acknowledge interrupts.

## Interface
- `NUM_SRC`, 8: number of interrupt sources, 1..8; unused upper bits read 0.
- `sys_clk  in  1`: system clock, all state on rising edge.
- `sys_reset  in  1`: asynchronous, active-low reset.
- `irq_src_i  in  NUM_SRC`: raw interrupt requests; bit 0 = timer.
- `wr_en_i  in  1`: register write strobe.
- `wr_addr_i  in  32`: write address; only [3:0] decoded.
- `wr_data_i  in  32`: write data.
- `rd_addr_i  in  32`: read address; only [3:0] decoded.
- `rd_data_o  out  32`: read data, combinational from `rd_addr_i`.
- `int_flag_o  out  8`: registered one-hot to CPU `int_flag_i`; all-zero = no interrupt.

## Operation
- Register map, byte offsets; addr[1:0] ≠ 0 or unmapped offsets: writes ignored, reads 0.
- 0x0 ENABLE[7:0], RW, reset 0x00. Masks the output only; pending latches regardless.
- 0x4 TRIG[7:0], RW, reset 0x00. 1 = rising edge, 0 = level.
- 0x8 PENDING[7:0]. Read returns pending. Write is W1C for edge sources; ignored for level sources.
- 0xC ID, RO. Bit 31 = any source is both pending and enabled. Bits [2:0] = lowest index among those sources, else 0. Writes ignored.
- Edge detect: `src_d` holds the previous sample. The edge condition is `irq_src_i & ~src_d`.
- Edge source: pending sets on edge and stays set until W1C.
- Level source: pending equals the registered sample of `irq_src_i`.
- Priority is fixed: bit 0 highest.
- `int_flag_o`: next value is one-hot of the ID winner when ID valid, else 0x00.
- Bits [7:NUM_SRC] of all registers and outputs are tied 0.

## Timing
- Reset (async assert, sync deassert): ENABLE, TRIG, PENDING, src_d, sync flops and `int_flag_o` are all 0x00. `rd_data_o` is combinational and reads 0 for every register.
- A source sampled high first at edge k gives PENDING = 1 after edge k and `int_flag_o` valid after edge k+1. Latency is 2 cycles; with the synchronizer it is 4.
- A register write at edge k takes effect after edge k. `int_flag_o` reflects the write after edge k+1.
- W1C at the same edge as a new edge on the same bit: set wins, and pending stays 1.
- TRIG change from level to edge: pending keeps its current value and then follows edge rules. From edge to level: pending is overwritten by the sample at the next edge.
- Source held high in edge mode: no re-set after W1C until it falls and rises again.
- Reset mid-operation: pending interrupts are lost and `int_flag_o` drops to 0 immediately (async).
- Read and write to the same address in the same cycle: the read returns the pre-write value.

## Configuration
- `INTC_SYNC_EN` defined: each `irq_src_i` bit passes through a 2-flop synchronizer, reset 0, before edge detect and level sampling. Total latency is 4 cycles. Use this for sources from other clock domains or pins.
- `INTC_SYNC_EN` undefined: sources are sampled directly and latency is 2 cycles. This is correct only for sources synchronous to `sys_clk`.

## Test plan
- Reset, then read 0x0/0x4/0x8/0xC → all 0x00000000; `int_flag_o` = 0x00.
- Write ENABLE=0x01, TRIG=0x01; pulse `irq_src_i[0]` for 1 cycle. PENDING reads 0x01, ID reads 0x80000000, and `int_flag_o` = 0x01 two cycles after sampling. Write 0x8 ← 0x01: PENDING = 0x00 and `int_flag_o` = 0x00 one cycle later.
- ENABLE=0xFF, TRIG=0x00; hold `irq_src_i` = 0x0C. ID = 0x80000002, `int_flag_o` = 0x04. Drop bit 2: ID = 0x80000003, `int_flag_o` = 0x08. W1C 0xFF has no effect.
- ENABLE=0x00, edge pulse on source 5: PENDING = 0x20, `int_flag_o` = 0x00. Write ENABLE=0x20: `int_flag_o` = 0x20 one cycle later.
- TRIG=0x02, new rising edge on source 1 in the same cycle as W1C 0x02 → PENDING stays 0x02. Hold source 1 high then W1C → stays 0x00 until the next rise.
- Assert `sys_reset` low mid-interrupt (`int_flag_o` = 0x01) → outputs 0 before the next clock edge. Repeat the edge scenario with `INTC_SYNC_EN` → latency 4 cycles.
